// File: rtl/als_ascii_formatter.sv
// -----------------------------------------------------------------------------
// als_ascii_formatter
//
// Turns each accepted 8-bit ambient-light reading into one fixed-width ASCII
// decimal line ("ddd" + terminator). The line is streamed byte by byte to the
// UART transmitter over a valid/ready handshake. The binary-to-BCD conversion
// is a serial double-dabble, one bit per clock.
//
// Optional feature (macro ALS_FMT_CR_EN):
//   defined   -> line is "ddd" CR LINE_END (5 bytes)
//   undefined -> line is "ddd" LINE_END    (4 bytes)
//
// Ports:
//   clk           in   1  system clock
//   reset         in   1  asynchronous, active-high; clears all state
//   sample        in   8  light reading, valid while sample_strobe=1
//   sample_strobe in   1  single-cycle "new reading" pulse
//   idle          out  1  no line in progress; a strobe now is accepted
//   tx_data       out  8  ASCII byte for the UART
//   tx_valid      out  1  tx_data holds a byte awaiting transfer
//   tx_ready      in   1  UART accepts a byte this cycle
//   drop_count    out  8  saturating count of strobes lost while busy
// -----------------------------------------------------------------------------
module als_ascii_formatter #(
  parameter logic [7:0] LINE_END = 8'h0A
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] sample,
  input  logic       sample_strobe,
  output logic       idle,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  output logic [7:0] drop_count
);

`ifdef ALS_FMT_CR_EN
  localparam logic [2:0] LAST_IDX = 3'd4;
`else
  localparam logic [2:0] LAST_IDX = 3'd3;
`endif

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CONVERT = 2'd1,
    SEND    = 2'd2
  } state_t;

  state_t      state;
  logic [7:0]  bin;      // binary operand being shifted out
  logic [11:0] bcd;      // hundreds / tens / ones nibbles
  logic [3:0]  bit_cnt;  // conversion steps still to perform
  logic [2:0]  idx;      // index of the byte currently on tx_data

  // One double-dabble step: add 3 to every nibble >= 5, then shift
  // {bcd, bin} left by one. Returns the new {bcd, bin}.
  function automatic logic [19:0] dabble_step(input logic [11:0] b,
                                              input logic [7:0]  n);
    logic [11:0] adj;
    adj = b;
    for (int i = 0; i < 3; i++) begin
      if (adj[i*4 +: 4] >= 4'd5) adj[i*4 +: 4] = adj[i*4 +: 4] + 4'd3;
    end
    return {adj[10:0], n, 1'b0};
  endfunction

  // ASCII byte for position i of the line.
  function automatic logic [7:0] line_byte(input logic [2:0]  i,
                                           input logic [11:0] b);
    logic [7:0] r;
    case (i)
      3'd0:    r = 8'h30 + {4'h0, b[11:8]};
      3'd1:    r = 8'h30 + {4'h0, b[7:4]};
      3'd2:    r = 8'h30 + {4'h0, b[3:0]};
`ifdef ALS_FMT_CR_EN
      3'd3:    r = 8'h0D;
`endif
      default: r = LINE_END;
    endcase
    return r;
  endfunction

  // NOTE: every register here is ordinary state (no memory array), so all of
  // it is cleared by the asynchronous reset; sequential state uses <= only.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      idle       <= 1'b1;
      tx_valid   <= 1'b0;
      tx_data    <= 8'h00;
      drop_count <= 8'h00;
      bin        <= 8'h00;
      bcd        <= 12'h000;
      bit_cnt    <= 4'd0;
      idx        <= 3'd0;
    end else begin
      // A strobe is lost whenever a line is in flight, including the cycle
      // in which the last byte transfers (idle is still 0 then).
      if (sample_strobe && !idle && drop_count != 8'hFF)
        drop_count <= drop_count + 8'd1;

      case (state)
        IDLE: begin
          if (sample_strobe) begin
            bin     <= sample;
            bcd     <= 12'h000;
            bit_cnt <= 4'd8;
            idle    <= 1'b0;
            state   <= CONVERT;
          end
        end

        CONVERT: begin
          if (bit_cnt != 4'd0) begin
            {bcd, bin} <= dabble_step(bcd, bin);
            bit_cnt    <= bit_cnt - 4'd1;
          end else begin
            // Digits became final on the previous edge. The first byte is
            // registered here, so tx_valid rises 9 edges after acceptance.
            idx      <= 3'd0;
            tx_data  <= line_byte(3'd0, bcd);
            tx_valid <= 1'b1;
            state    <= SEND;
          end
        end

        SEND: begin
          // tx_data and idx hold while the UART stalls.
          if (tx_ready) begin
            if (idx == LAST_IDX) begin
              tx_valid <= 1'b0;
              idle     <= 1'b1;
              state    <= IDLE;
            end else begin
              idx     <= idx + 3'd1;
              tx_data <= line_byte(idx + 3'd1, bcd);
            end
          end
        end

        default: begin
          state    <= IDLE;
          idle     <= 1'b1;
          tx_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_als_ascii_formatter.sv
// -----------------------------------------------------------------------------
// tb_als_ascii_formatter
//
// Self-checking bench for als_ascii_formatter: a table of samples with their
// hand-computed ASCII digits, plus directed sequences for reset mid-line,
// handshake stalls, drops, saturation and the end-of-line strobe boundary.
// -----------------------------------------------------------------------------
module tb_als_ascii_formatter;

`ifdef ALS_FMT_CR_EN
  localparam int LINE_LEN = 5;
`else
  localparam int LINE_LEN = 4;
`endif

  logic       clk;
  logic       reset;
  logic [7:0] sample;
  logic       sample_strobe;
  logic       idle;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready;
  logic [7:0] drop_count;

  int vectors     = 0;
  int miscompares = 0;

  als_ascii_formatter #(.LINE_END(8'h0A)) dut (
    .clk           (clk),
    .reset         (reset),
    .sample        (sample),
    .sample_strobe (sample_strobe),
    .idle          (idle),
    .tx_data       (tx_data),
    .tx_valid      (tx_valid),
    .tx_ready      (tx_ready),
    .drop_count    (drop_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] value;
    logic [7:0] d0;
    logic [7:0] d1;
    logic [7:0] d2;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Advance one clock; inputs are driven and outputs sampled 1 ns after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic strobe(input logic [7:0] v);
    sample        = v;
    sample_strobe = 1'b1;
    tick();
    sample_strobe = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    #3;
    reset = 1'b0;
    tick();
  endtask

  // Collect one full line. mode 0: tx_ready held 1; mode 1: tx_ready follows
  // 1,0,0,1 repeatedly. Checks tx_data stability during stalls, the byte
  // sequence, and the return to idle.
  task automatic collect_line(input int mode, input logic [7:0] e0,
                              input logic [7:0] e1, input logic [7:0] e2,
                              input string tag);
    logic [7:0] got [0:4];
    logic [7:0] exp [0:4];
    logic [7:0] prev;
    logic       stalled;
    int n;
    int cyc;
    exp[0] = e0; exp[1] = e1; exp[2] = e2;
`ifdef ALS_FMT_CR_EN
    exp[3] = 8'h0D; exp[4] = 8'h0A;
`else
    exp[3] = 8'h0A; exp[4] = 8'h00;
`endif
    n = 0; cyc = 0; stalled = 1'b0; prev = 8'h00;
    while (n < LINE_LEN && cyc < 200) begin
      tx_ready = (mode == 0) ? 1'b1 : ((cyc % 4 == 0) || (cyc % 4 == 3));
      if (stalled && tx_valid)
        check({tag, " stall hold"}, {24'h0, tx_data}, {24'h0, prev});
      if (tx_valid && tx_ready) begin
        got[n] = tx_data;
        n++;
      end
      stalled = tx_valid && !tx_ready;
      prev    = tx_data;
      tick();
      cyc++;
    end
    tx_ready = 1'b1;
    check({tag, " byte count"}, n, LINE_LEN);
    for (int i = 0; i < LINE_LEN; i++)
      if (i < n) check($sformatf("%s byte%0d", tag, i), {24'h0, got[i]}, {24'h0, exp[i]});
    check({tag, " idle after"}, {31'h0, idle}, 32'd1);
    check({tag, " valid after"}, {31'h0, tx_valid}, 32'd0);
  endtask

  task automatic wait_valid(input string tag);
    int k;
    k = 0;
    while (!tx_valid && k < 50) begin
      tick();
      k++;
    end
    check({tag, " valid timeout"}, {31'h0, tx_valid}, 32'd1);
  endtask

  vec_t tbl [0:9];

  initial begin
    reset = 1'b0; sample = 8'h00; sample_strobe = 1'b0; tx_ready = 1'b1;

    tbl[0] = '{8'd0,   8'h30, 8'h30, 8'h30};
    tbl[1] = '{8'd7,   8'h30, 8'h30, 8'h37};
    tbl[2] = '{8'd9,   8'h30, 8'h30, 8'h39};
    tbl[3] = '{8'd10,  8'h30, 8'h31, 8'h30};
    tbl[4] = '{8'd42,  8'h30, 8'h34, 8'h32};
    tbl[5] = '{8'd99,  8'h30, 8'h39, 8'h39};
    tbl[6] = '{8'd100, 8'h31, 8'h30, 8'h30};
    tbl[7] = '{8'd128, 8'h31, 8'h32, 8'h38};
    tbl[8] = '{8'd199, 8'h31, 8'h39, 8'h39};
    tbl[9] = '{8'd255, 8'h32, 8'h35, 8'h35};

    do_reset();
    check("reset idle",     {31'h0, idle},     32'd1);
    check("reset tx_valid", {31'h0, tx_valid}, 32'd0);
    check("reset tx_data",  {24'h0, tx_data},  32'h00);
    check("reset drops",    {24'h0, drop_count}, 32'd0);

    // Table: latency (valid low after E+8, high after E+9) and byte content.
    for (int v = 0; v < 10; v++) begin
      strobe(tbl[v].value);
      check($sformatf("v%0d idle busy", v), {31'h0, idle}, 32'd0);
      for (int k = 1; k <= 9; k++) begin
        tick();
        if (k == 8) check($sformatf("v%0d valid E+8", v), {31'h0, tx_valid}, 32'd0);
        if (k == 9) check($sformatf("v%0d valid E+9", v), {31'h0, tx_valid}, 32'd1);
      end
      collect_line(0, tbl[v].d0, tbl[v].d1, tbl[v].d2, $sformatf("v%0d", v));
    end
    check("table drops", {24'h0, drop_count}, 32'd0);

    // Reset mid-SEND with the UART stalled: tx_valid must drop without a clk edge.
    strobe(8'd5);
    wait_valid("rst");
    tx_ready = 1'b0;
    tick();
    #2;
    reset = 1'b1;
    #1;
    check("rst async valid", {31'h0, tx_valid}, 32'd0);
    check("rst async idle",  {31'h0, idle},     32'd1);
    #1;
    reset = 1'b0;
    tick();
    check("rst idle after",  {31'h0, idle},       32'd1);
    check("rst drops after", {24'h0, drop_count}, 32'd0);
    tx_ready = 1'b1;
    strobe(8'd9);
    wait_valid("rst 009");
    collect_line(0, 8'h30, 8'h30, 8'h39, "rst 009");

    // 255 with tx_ready toggling 1,0,0,1.
    strobe(8'd255);
    wait_valid("stall");
    collect_line(1, 8'h32, 8'h35, 8'h35, "stall");

    // Second strobe three cycles after the first is dropped.
    strobe(8'd128);
    tick();
    tick();
    strobe(8'd77);
    check("drop one", {24'h0, drop_count}, 32'd1);
    wait_valid("drop");
    collect_line(0, 8'h31, 8'h32, 8'h38, "drop");
    for (int k = 0; k < 12; k++) tick();
    check("drop no 2nd line", {31'h0, tx_valid}, 32'd0);

    // 300 strobes with tx_ready held 0: first accepted, the rest saturate.
    do_reset();
    tx_ready = 1'b0;
    strobe(8'd100);
    for (int k = 1; k < 300; k++) strobe(8'(k));
    check("sat count",   {24'h0, drop_count}, 32'd255);
    check("sat tx_data", {24'h0, tx_data},    32'h31);
    check("sat valid",   {31'h0, tx_valid},   32'd1);
    collect_line(0, 8'h31, 8'h30, 8'h30, "sat");
    check("sat hold", {24'h0, drop_count}, 32'd255);

    // Strobe on the cycle the last byte transfers is dropped; one cycle
    // later (first IDLE cycle) a strobe is accepted.
    do_reset();
    tx_ready = 1'b1;
    strobe(8'd3);
    wait_valid("edge");
    for (int i = 0; i < LINE_LEN; i++) begin
      if (i == LINE_LEN - 1) begin
        sample = 8'd200;
        sample_strobe = 1'b1;
      end
      tick();
    end
    sample_strobe = 1'b0;
    check("edge drop",  {24'h0, drop_count}, 32'd1);
    check("edge idle",  {31'h0, idle},       32'd1);
    strobe(8'd42);
    check("edge accepted", {31'h0, idle}, 32'd0);
    wait_valid("edge 042");
    collect_line(0, 8'h30, 8'h34, 8'h32, "edge 042");
    check("edge drops final", {24'h0, drop_count}, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
